// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Default 640x480@60 timing constants and the receiver FSM
//               state type shared by the VGA sync receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Horizontal timing in pixels
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL       = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  // Vertical timing in lines
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL       = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Registers an active-low sync input once, keeps a one-cycle
//               delayed copy and flags the cycle where the registered sync
//               has just fallen. History presets high so reset never fakes
//               an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic fall
);

  logic sync_q;
  logic sync_dly;

  // Input register plus delayed copy; both idle high (sync inactive)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 1'b1;
      sync_dly <= 1'b1;
    end else begin
      sync_q   <= sync_in;
      sync_dly <= sync_q;
    end
  end

  assign fall = sync_dly & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_receiver
// Description : Recovers pixel timing from VGA hsync/vsync, verifies line and
//               frame lengths, and emits visible-pixel strobes with x/y
//               coordinates and captured RGB. Input-to-output latency is two
//               clocks.
//               Optional macro VGA_RX_CHECKSUM_EN adds the frame_sum output
//               (wrapping per-frame sum of red+green+blue over valid pixels).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        locked,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        frame_start,
  output logic        sync_error,
  output logic [15:0] frame_count
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);

  localparam int LINE_LEN    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_START     = H_SYNC + H_BP;
  localparam int V_START     = V_SYNC + V_BP;
  localparam int HCW         = $clog2(LINE_LEN + 1);
  localparam int VCW         = $clog2(FRAME_LINES + 1);

  logic           hs_fall;
  logic           vs_fall;
  logic [7:0]     red_q, green_q, blue_q;
  logic [HCW-1:0] hcount, h_next;
  logic [VCW-1:0] vcount, v_next;
  logic           vs_pend;
  logic           line_err;
  logic           frame_evt;
  logic           err;
  logic           h_vis, v_vis, show;
  rx_state_t      state, state_next;

  sync_edge_detect u_hs_edge (.clk(clk_25), .rst(rst), .sync_in(hsync), .fall(hs_fall));
  sync_edge_detect u_vs_edge (.clk(clk_25), .rst(rst), .sync_in(vsync), .fall(vs_fall));

  // First pipeline stage for pixel data, aligned with the registered syncs
  always_ff @(posedge clk_25) begin
    if (rst) begin
      red_q   <= 8'd0;
      green_q <= 8'd0;
      blue_q  <= 8'd0;
    end else begin
      red_q   <= red;
      green_q <= green;
      blue_q  <= blue;
    end
  end

  // Position of the stage-one pixel; a vsync fall takes effect at the next hsync fall
  always_comb begin
    h_next = hcount + HCW'(1);
    if (hs_fall) h_next = '0;
    v_next = vcount;
    if (hs_fall) begin
      if (vs_fall || vs_pend) v_next = '0;
      else                    v_next = vcount + VCW'(1);
    end
  end

  // hcount/vcount hold the position of the pixel now at the outputs
  always_ff @(posedge clk_25) begin
    if (rst) begin
      hcount  <= '0;
      vcount  <= '0;
      vs_pend <= 1'b0;
    end else begin
      hcount  <= h_next;
      vcount  <= v_next;
      vs_pend <= hs_fall ? 1'b0 : (vs_pend | vs_fall);
    end
  end

  // A line is bad if it ends early/late, or runs to LINE_LEN with no hsync fall
  assign line_err = hs_fall ? (hcount != HCW'(LINE_LEN - 1))
                            : (hcount == HCW'(LINE_LEN - 1));

  // Receiver state register
  always_ff @(posedge clk_25) begin
    if (rst) state <= SEARCH;
    else     state <= state_next;
  end

  // Lock FSM: an error always wins over a frame event in the same cycle
  always_comb begin
    state_next = state;
    frame_evt  = 1'b0;
    err        = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) state_next = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (line_err) begin
          err        = 1'b1;
          state_next = SEARCH;
        end else if (vs_fall) begin
          if (vcount == VCW'(FRAME_LINES - 1)) begin
            frame_evt  = 1'b1;
            state_next = LOCKED;
          end else begin
            err        = 1'b1;
            state_next = SEARCH;
          end
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  assign h_vis = (h_next >= HCW'(H_START)) && (h_next < HCW'(H_START + H_VISIBLE));
  assign v_vis = (v_next >= VCW'(V_START)) && (v_next < VCW'(V_START + V_VISIBLE));
  assign show  = (state_next == LOCKED) && h_vis && v_vis;

  assign locked = (state == LOCKED);

  // Output stage: strobes every cycle, coordinates and data only on valid pixels
  always_ff @(posedge clk_25) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      sync_error  <= 1'b0;
      frame_count <= 16'd0;
      x           <= 10'd0;
      y           <= 10'd0;
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
    end else begin
      pixel_valid <= show;
      frame_start <= frame_evt;
      sync_error  <= err;
      if (frame_evt) frame_count <= frame_count + 16'd1;
      if (show) begin
        x     <= 10'(h_next - HCW'(H_START));
        y     <= 10'(v_next - VCW'(V_START));
        pix_r <= red_q;
        pix_g <= green_q;
        pix_b <= blue_q;
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] sum_acc;

  // Running colour sum restarts at each frame start, publishing the finished frame
  always_ff @(posedge clk_25) begin
    if (rst) begin
      sum_acc   <= 16'd0;
      frame_sum <= 16'd0;
    end else if (frame_evt) begin
      frame_sum <= sum_acc;
      sum_acc   <= 16'd0;
    end else if (show) begin
      sum_acc <= sum_acc + 16'(red_q) + 16'(green_q) + 16'(blue_q);
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal porch and sync widths in pixels, so H_TOTAL = 800.
REQ-003 SHALL have parameters V_VISIBLE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical widths in lines, so V_TOTAL = 525.
REQ-004 SHALL have ports: clk_25 input 1: pixel clock; all logic on rising edge.
REQ-005 SHALL have port rst input 1: synchronous reset, active-high.
REQ-006 SHALL have ports hsync and vsync, input 1 each: active-low syncs from the VGA source.
REQ-007 SHALL have ports red/green/blue input 8 each: pixel data.
REQ-008 SHALL have port locked output 1: timing verified and tracking.
REQ-009 SHALL have ports pixel_valid output 1, x output 10 and y output 10: visible-pixel strobe and coordinates.
REQ-010 SHALL have ports pix_r/pix_g/pix_b output 8 each: captured pixel data.
REQ-011 SHALL have ports frame_start output 1, sync_error output 1 and frame_count output 16: one-cycle pulses and frame counter.

Function
REQ-012 SHALL register hsync, vsync and RGB once, then detect falling edges on the registered syncs via a one-cycle-delayed copy.
REQ-013 SHALL set hcount to 0 on a detected hsync falling edge, otherwise increment; vcount SHALL increment on each hsync fall, or become 0 on the first hsync fall at or after a vsync fall (same-cycle coincidence included).
REQ-014 SHALL implement FSM SEARCH -> MEASURE -> LOCKED; reset and any error SHALL enter SEARCH.
REQ-015 In SEARCH, a vsync fall SHALL enter MEASURE.
REQ-016 In MEASURE, at the next vsync fall with vcount == V_TOTAL-1 and no line error, the FSM SHALL enter LOCKED; otherwise it SHALL pulse sync_error and return to SEARCH.
REQ-017 In MEASURE or LOCKED, a line error SHALL pulse sync_error and enter SEARCH. A line error is an hsync fall with hcount != H_TOTAL-1, or hcount reaching H_TOTAL with no hsync fall.
REQ-018 In LOCKED, a vsync fall with vcount != V_TOTAL-1 SHALL pulse sync_error and enter SEARCH.
REQ-019 locked SHALL be 1 exactly while the FSM is in LOCKED.
REQ-020 pixel_valid SHALL be 1 when locked, hcount is in [H_SYNC+H_BP, H_SYNC+H_BP+H_VISIBLE) and vcount is in [V_SYNC+V_BP, V_SYNC+V_BP+V_VISIBLE).
REQ-021 With pixel_valid, x SHALL equal hcount-144, y SHALL equal vcount-35 (default parameters), and pix_* SHALL carry that pixel's data.
REQ-022 Total latency from input pin to outputs SHALL be 2 cycles; x, y and pix_* SHALL hold their last values when pixel_valid is 0.
REQ-023 frame_start SHALL pulse for one cycle on each vsync fall that enters or remains in LOCKED; frame_count SHALL increment on it, wrapping 0xFFFF -> 0.
REQ-024 When sync_error and a frame event occur in the same cycle, the error SHALL win: no frame_start pulse and no frame_count increment.

Reset
REQ-025 rst SHALL force FSM=SEARCH and hcount=vcount=0.
REQ-026 rst SHALL clear locked, pixel_valid, frame_start, sync_error, x, y, pix_* and frame_count to 0.
REQ-027 rst SHALL preset the sync history registers to 1, so no false edge is seen after reset.
REQ-028 rst asserted mid-frame SHALL take effect on the next edge; relock SHALL require a full new MEASURE frame.

Configuration
REQ-029 With macro VGA_RX_CHECKSUM_EN defined, the block SHALL add output frame_sum (16 bits): a wrapping sum of red+green+blue over the valid pixels of a frame.
REQ-030 The running sum SHALL clear at each frame_start; frame_sum SHALL update with the completed frame's sum at the next frame_start, and SHALL be 0 after reset.
REQ-031 Without VGA_RX_CHECKSUM_EN, the port and its logic SHALL be absent.

Structure
REQ-032 Package vga_pkg SHALL hold the default timing constants, H_TOTAL/V_TOTAL, and the FSM enum rx_state_t {SEARCH, MEASURE, LOCKED}.
REQ-033 A sub-module sync_edge_detect (register, delay, falling-edge pulse) SHALL be instantiated once for hsync and once for vsync.

Verification
REQ-034 Bench SHALL drive two clean 640x480 frames after reset and check locked rises at the second vsync fall, together with frame_start=1 and frame_count=1.
REQ-035 Bench SHALL, while locked, check the first valid pixel has x=0, y=0 and the last has x=639, y=479, with exactly 307200 pixel_valid cycles per frame.
REQ-036 Bench SHALL, while locked, shorten one line to 799 clocks and check sync_error pulses once and locked=0 the next cycle, then check relock after two clean frames.
REQ-037 Bench SHALL, while locked, hold hsync high and check sync_error when hcount reaches 800.
REQ-038 Bench SHALL, with VGA_RX_CHECKSUM_EN, drive a solid-red frame (255,0,0) and check frame_sum = 0x5000 at the following frame_start.
REQ-039 Bench SHALL assert rst for 1 cycle mid-frame and check all outputs are 0 the next cycle and no lock before one full MEASURE frame.
